// File: rtl/fpu_div_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM state encoding and index-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_div_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_RESP  = 2'd3
  } fpuDivArbState_t;

  // Width needed to hold a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpu_rr_pick.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on o_found.
//
// Ports:
//   i_req    - request vector, one bit per requester
//   i_rr_ptr - index that has highest priority this round
//   o_found  - at least one request is asserted
//   o_winner - index of the selected requester (0 when o_found is low)
module fpu_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_winner
);

  // One extra bit so ptr + offset can be folded back below N_REQ.
  localparam int SW = IDX_W + 1;

  logic [SW-1:0] w_sum;

  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_sum    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, i_rr_ptr} + SW'(k);
      if (w_sum >= SW'(N_REQ)) begin
        w_sum = w_sum - SW'(N_REQ);
      end
      if (!o_found && i_req[w_sum[IDX_W-1:0]]) begin
        o_found  = 1'b1;
        o_winner = w_sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fpu_div_arbiter.sv
// Shares one divider among N_REQ requesters with round-robin grant, div-by-zero bypass and watchdog.
// Latency: grant 1 cycle after request; response 1 cycle after divDone (div-by-zero: 1 cycle after grant).
// Backpressure: requesters hold req/operands until gnt; only one divide is in flight at a time.
//
// Ports:
//   clock, reset            - clock and asynchronous active-low reset
//   req, reqA, reqB         - per-requester request level, dividend and divisor (packed, requester i at [i*WIDTH +: WIDTH])
//   gnt                     - one-hot grant pulse
//   divIn1, divIn2, divStart- latched operands and start pulse to the divider
//   divOut, divDone         - quotient and completion from the divider
//   rspValid, rspData       - one-hot response strobe and quotient
//   rspDivZero, rspTimeout  - response flags, meaningful with rspValid
//   busy                    - arbiter is not idle
module fpu_div_arbiter
  import fpu_div_arbiter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] reqA,
  input  logic [N_REQ*WIDTH-1:0] reqB,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       divIn1,
  output logic [WIDTH-1:0]       divIn2,
  output logic                   divStart,
  input  logic [WIDTH-1:0]       divOut,
  input  logic                   divDone,
  output logic [N_REQ-1:0]       rspValid,
  output logic [WIDTH-1:0]       rspData,
  output logic                   rspDivZero,
  output logic                   rspTimeout,
  output logic                   busy
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  fpuDivArbState_t  r_state;
  fpuDivArbState_t  w_next_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_wdog;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_div_in1;
  logic [WIDTH-1:0] r_div_in2;
  logic             r_div_zero;
  logic             r_timeout;

  logic             w_found;
  logic [IDX_W-1:0] w_winner;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic             w_wdog_expired;
  logic             w_divisor_zero;
  logic [N_REQ-1:0] w_owner_1h;

  fpu_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  // Operand select for the winning requester.
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_opa = reqA[i*WIDTH +: WIDTH];
        w_opb = reqB[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_wdog_expired = (r_wdog == CNT_W'(TIMEOUT - 1));
  assign w_divisor_zero = (r_div_in2 == '0);
  assign w_owner_1h     = N_REQ'(1) << r_owner;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:  if (w_found) w_next_state = ARB_ISSUE;
      ARB_ISSUE: w_next_state = w_divisor_zero ? ARB_RESP : ARB_BUSY;
      ARB_BUSY:  if (divDone || w_wdog_expired) w_next_state = ARB_RESP;
      ARB_RESP:  w_next_state = ARB_IDLE;
      default:   w_next_state = ARB_IDLE;
    endcase
  end

  // Outputs decoded from state plus registered datapath only
  always_comb begin
    gnt      = '0;
    divStart = 1'b0;
    rspValid = '0;
    rspData  = '0;
    busy     = (r_state != ARB_IDLE);
    case (r_state)
      ARB_ISSUE: begin
        gnt      = w_owner_1h;
        divStart = !w_divisor_zero;
      end
      ARB_RESP: begin
        rspValid = w_owner_1h;
        rspData  = r_result;
      end
      default: ;
    endcase
  end

  assign divIn1     = r_div_in1;
  assign divIn2     = r_div_in2;
  assign rspDivZero = r_div_zero;
  assign rspTimeout = r_timeout;

  // Datapath: owner/operand capture, watchdog, result and flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_wdog     <= '0;
      r_result   <= '0;
      r_div_in1  <= '0;
      r_div_in2  <= '0;
      r_div_zero <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_owner   <= w_winner;
            r_div_in1 <= w_opa;
            r_div_in2 <= w_opb;
          end
        end
        ARB_ISSUE: begin
          r_wdog <= '0;
          if (w_divisor_zero) begin
            r_result   <= '1;
            r_div_zero <= 1'b1;
          end
        end
        ARB_BUSY: begin
          // A completion in the watchdog's last cycle still counts as success.
          if (divDone) begin
            r_result <= divOut;
          end else if (w_wdog_expired) begin
            r_result  <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog + CNT_W'(1);
          end
        end
        ARB_RESP: begin
          r_rr_ptr   <= (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
          r_div_zero <= 1'b0;
          r_timeout  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_arbiter.sv
module tb_fpu_div_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N*W-1:0] reqA = '0;
  logic [N*W-1:0] reqB = '0;
  logic [N-1:0] gnt, rspValid;
  logic [W-1:0] divIn1, divIn2, divOut, rspData;
  logic         divStart, divDone, rspDivZero, rspTimeout, busy;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  // Divider stub: done exactly stub_lat cycles after the start pulse.
  int         stub_lat  = 5;
  bit         stub_hang = 1'b0;
  logic       inj_done  = 1'b0;
  logic       stub_done;
  logic [W-1:0] stub_q;
  int         scnt;
  bit         sact;

  assign divDone = stub_done | inj_done;
  assign divOut  = stub_q;

  fpu_div_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .reqA(reqA), .reqB(reqB),
    .gnt(gnt), .divIn1(divIn1), .divIn2(divIn2), .divStart(divStart),
    .divOut(divOut), .divDone(divDone), .rspValid(rspValid), .rspData(rspData),
    .rspDivZero(rspDivZero), .rspTimeout(rspTimeout), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      stub_done <= 1'b0; stub_q <= '0; scnt <= 0; sact <= 1'b0;
    end else begin
      stub_done <= 1'b0;
      if (divStart) begin
        stub_q    <= divIn1 / divIn2;
        scnt      <= 1;
        sact      <= (stub_lat != 1);
        stub_done <= (stub_lat == 1) && !stub_hang;
      end else if (sact) begin
        scnt <= scnt + 1;
        if (scnt + 1 == stub_lat) begin
          stub_done <= !stub_hang;
          sact      <= 1'b0;
        end
      end
    end
  end

  // Reference arbitration: first pending requester at or after ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    reqA[i*W +: W] = a;
    reqB[i*W +: W] = b;
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b0; req = '0; inj_done = 1'b0;
    step();
    step();
    reset = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({gnt, divStart, rspValid, rspData, rspDivZero, rspTimeout, busy, divIn1, divIn2} !== '0) begin
        failures++;
        $display("FAIL reset_outs c=%0d got=%h exp=0", c,
                 {gnt, divStart, rspValid, rspData, rspDivZero, rspTimeout, busy, divIn1, divIn2});
      end
      step();
    end
    reset = 1'b1;
    m_ptr = 0;
    step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    logic [N-1:0] eg, ev;
    stub_lat = 5;
    step();
    set_op(2, 16'd100, 16'd7);
    req = 4'b0100;
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt c=0 got=%b exp=0000", gnt); end
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 2) req[2] = 1'b0;
      eg = (c == 1) ? 4'b0100 : 4'b0000;
      ev = (c == 7) ? 4'b0100 : 4'b0000;
      checks++;
      if (gnt !== eg) begin failures++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      checks++;
      if (divStart !== (c == 1)) begin failures++; $display("FAIL single_start c=%0d got=%b exp=%b", c, divStart, (c == 1)); end
      checks++;
      if (rspValid !== ev) begin failures++; $display("FAIL single_rsp c=%0d got=%b exp=%b", c, rspValid, ev); end
      checks++;
      if (busy !== (c <= 7)) begin failures++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, (c <= 7)); end
      if (c == 7) begin
        checks++;
        if (rspData !== 16'd14 || rspDivZero !== 1'b0 || rspTimeout !== 1'b0) begin
          failures++;
          $display("FAIL single_data got=%0d/%b/%b exp=14/0/0", rspData, rspDivZero, rspTimeout);
        end
      end
    end
    m_ptr = 3;
  endtask

  task automatic test_divzero();
    logic [N-1:0] eg, ev;
    step();
    set_op(1, 16'd5, 16'd0);
    req = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 2) req[1] = 1'b0;
      eg = (c == 1) ? 4'b0010 : 4'b0000;
      ev = (c == 2) ? 4'b0010 : 4'b0000;
      checks++;
      if (gnt !== eg) begin failures++; $display("FAIL dz_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      checks++;
      if (rspValid !== ev) begin failures++; $display("FAIL dz_rsp c=%0d got=%b exp=%b", c, rspValid, ev); end
      checks++;
      if (divStart !== 1'b0) begin failures++; $display("FAIL dz_start c=%0d got=%b exp=0", c, divStart); end
      if (c == 2) begin
        checks++;
        if (rspData !== 16'hFFFF || rspDivZero !== 1'b1 || rspTimeout !== 1'b0) begin
          failures++;
          $display("FAIL dz_data got=%h/%b/%b exp=ffff/1/0", rspData, rspDivZero, rspTimeout);
        end
      end
      if (c == 3) begin
        checks++;
        if (rspDivZero !== 1'b0) begin failures++; $display("FAIL dz_flag_clear got=%b exp=0", rspDivZero); end
      end
    end
    m_ptr = 2;
  endtask

  task automatic test_operand_stability();
    logic [N-1:0] ev;
    stub_lat = 3;
    step();
    set_op(0, 16'd200, 16'd10);
    req = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) begin set_op(0, 16'd999, 16'd1); req = '0; end
      ev = (c == 5) ? 4'b0001 : 4'b0000;
      checks++;
      if (rspValid !== ev) begin failures++; $display("FAIL stab_rsp c=%0d got=%b exp=%b", c, rspValid, ev); end
      if (c == 3) begin
        checks++;
        if (divIn1 !== 16'd200 || divIn2 !== 16'd10) begin
          failures++; $display("FAIL stab_operands got=%0d/%0d exp=200/10", divIn1, divIn2);
        end
      end
      if (c == 5) begin
        checks++;
        if (rspData !== 16'd20) begin failures++; $display("FAIL stab_data got=%0d exp=20", rspData); end
      end
    end
    m_ptr = 1;
  endtask

  task automatic test_watchdog();
    logic [N-1:0] eg, ev;
    apply_reset();
    stub_hang = 1'b1;
    stub_lat  = 3;
    step();
    set_op(0, 16'd9, 16'd3);
    req = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 2)  req = '0;
      if (c == 12) inj_done = 1'b1;
      if (c == 13) inj_done = 1'b0;
      eg = (c == 1)  ? 4'b0001 : 4'b0000;
      ev = (c == 10) ? 4'b0001 : 4'b0000;
      checks++;
      if (gnt !== eg) begin failures++; $display("FAIL wd_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      checks++;
      if (rspValid !== ev) begin failures++; $display("FAIL wd_rsp c=%0d got=%b exp=%b", c, rspValid, ev); end
      checks++;
      if (busy !== (c <= 10)) begin failures++; $display("FAIL wd_busy c=%0d got=%b exp=%b", c, busy, (c <= 10)); end
      if (c == 10) begin
        checks++;
        if (rspData !== 16'd0 || rspTimeout !== 1'b1 || rspDivZero !== 1'b0) begin
          failures++; $display("FAIL wd_data got=%0d/%b/%b exp=0/1/0", rspData, rspTimeout, rspDivZero);
        end
      end
    end
    stub_hang = 1'b0;
    m_ptr = 1;
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] eg, ev;
    logic [W-1:0] ed;
    stub_lat = 20;
    step();
    set_op(3, 16'd50, 16'd5);
    req = 4'b1000;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) begin
        checks++;
        if (gnt !== 4'b1000) begin failures++; $display("FAIL rmo_first_gnt got=%b exp=1000", gnt); end
      end
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rmo_busy got=%b exp=1", busy); end
    #1 reset = 1'b0;
    req = '0;
    #1;
    checks++;
    if ({gnt, divStart, rspValid, rspData, rspDivZero, rspTimeout, busy, divIn1, divIn2} !== '0) begin
      failures++; $display("FAIL rmo_async_clear got=%h exp=0",
                           {gnt, divStart, rspValid, rspData, rspDivZero, rspTimeout, busy, divIn1, divIn2});
    end
    step();
    checks++;
    if (rspValid !== '0 || busy !== 1'b0) begin failures++; $display("FAIL rmo_held got=%b/%b exp=0/0", rspValid, busy); end
    step();
    reset = 1'b1;
    m_ptr = 0;
    stub_lat = 2;
    step();
    set_op(0, 16'd40, 16'd8);
    set_op(3, 16'd60, 16'd6);
    req = 4'b1001;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 2) req[0] = 1'b0;
      if (c == 7) req[3] = 1'b0;
      eg = (c == 1) ? 4'b0001 : (c == 6) ? 4'b1000 : 4'b0000;
      ev = (c == 4) ? 4'b0001 : (c == 9) ? 4'b1000 : 4'b0000;
      ed = (c == 4) ? 16'd5 : 16'd10;
      checks++;
      if (gnt !== eg) begin failures++; $display("FAIL rmo_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      checks++;
      if (rspValid !== ev) begin failures++; $display("FAIL rmo_rsp c=%0d got=%b exp=%b", c, rspValid, ev); end
      if (ev != '0) begin
        checks++;
        if (rspData !== ed) begin failures++; $display("FAIL rmo_data c=%0d got=%0d exp=%0d", c, rspData, ed); end
      end
    end
    m_ptr = 0;
  endtask

  task automatic test_fairness();
    int order[5] = '{0, 1, 2, 3, 0};
    int ng = 0, nr = 0, own = -1, last = -1, drop = -1;
    logic [W-1:0] ea, eb;
    apply_reset();
    stub_lat = $urandom_range(1, 4);
    step();
    for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom_range(1, 200)));
    req = '1;
    for (int t = 0; t < 400 && nr < 5; t++) begin
      step();
      if (drop >= 0) begin req[drop] = 1'b0; drop = -1; end
      if (gnt !== '0) begin
        checks++;
        if (ng >= 5 || gnt !== (N'(1) << order[ng])) begin
          failures++; $display("FAIL fair_order n=%0d got=%b exp=%0d", ng, gnt, (ng < 5) ? order[ng] : -1);
        end
        own = model_pick(gnt, 0);
        checks++;
        if (own == last) begin failures++; $display("FAIL fair_repeat got=%0d exp!=%0d", own, last); end
        last = own;
        if (own < 0) own = 0;
        ea = reqA[own*W +: W];
        eb = reqB[own*W +: W];
        drop = own;
        ng++;
      end
      if (rspValid !== '0) begin
        checks++;
        if (rspValid !== (N'(1) << own) || rspData !== ea / eb) begin
          failures++; $display("FAIL fair_rsp got=%b/%0d exp=%0d/%0d", rspValid, rspData, own, ea / eb);
        end
        nr++;
        m_ptr = (own + 1) % N;
        if (nr >= 5) begin
          req = '0;
        end else begin
          set_op(own, W'($urandom), W'($urandom_range(1, 200)));
          req[own] = 1'b1;
        end
      end
    end
    checks++;
    if (nr < 5) begin failures++; $display("FAIL fair_budget got=%0d exp=5 responses", nr); end
    step();
    step();
  endtask

  task automatic test_random();
    int ng = 0, own = 0, gt = 0, tr = 0, lat_g = 0, drop = -1, exp_w;
    bit outst = 1'b0;
    logic [W-1:0] ea, eb, ed;
    step();
    stub_lat = $urandom_range(1, 6);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 1) == 1 || i == 3) begin
        set_op(i, W'($urandom), ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 300)));
        req[i] = 1'b1;
      end
    end
    for (int t = 1; t < 5000 && ng < 60; t++) begin
      step();
      if (drop >= 0) begin req[drop] = 1'b0; drop = -1; end
      if (gnt !== '0) begin
        checks++;
        if (outst) begin failures++; $display("FAIL rnd_overlap t=%0d got=%b exp=0000", t, gnt); end
        exp_w = model_pick(req, m_ptr);
        checks++;
        if (exp_w < 0 || gnt !== (N'(1) << exp_w)) begin
          failures++; $display("FAIL rnd_gnt t=%0d got=%b exp=%0d", t, gnt, exp_w);
        end
        own = (exp_w < 0) ? 0 : exp_w;
        ea = reqA[own*W +: W];
        eb = reqB[own*W +: W];
        gt = t; lat_g = stub_lat; outst = 1'b1; drop = own; ng++;
      end
      if (rspValid !== '0) begin
        ed = (eb == 0) ? '1 : ea / eb;
        checks++;
        if (rspValid !== (N'(1) << own) || rspData !== ed) begin
          failures++; $display("FAIL rnd_rsp t=%0d got=%b/%h exp=%0d/%h", t, rspValid, rspData, own, ed);
        end
        checks++;
        if (rspDivZero !== (eb == 0) || rspTimeout !== 1'b0) begin
          failures++; $display("FAIL rnd_flags got=%b/%b exp=%b/0", rspDivZero, rspTimeout, (eb == 0));
        end
        checks++;
        if (t - gt != ((eb == 0) ? 1 : lat_g + 1)) begin
          failures++; $display("FAIL rnd_latency got=%0d exp=%0d", t - gt, (eb == 0) ? 1 : lat_g + 1);
        end
        outst = 1'b0; tr = t;
        m_ptr = (own + 1) % N;
        stub_lat = $urandom_range(1, 6);
        for (int i = 0; i < N; i++) begin
          if (!req[i] && $urandom_range(0, 1) == 1) begin
            set_op(i, W'($urandom), ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 300)));
            req[i] = 1'b1;
          end
        end
        if (req == '0) begin
          set_op(own, W'($urandom), W'($urandom_range(1, 300)));
          req[own] = 1'b1;
        end
      end else if (outst && (t - gt) > lat_g + 2) begin
        checks++; failures++;
        $display("FAIL rnd_no_rsp t=%0d got=none exp=rsp by %0d", t, gt + lat_g + 1);
        break;
      end else if (!outst && (t - tr) > 3) begin
        checks++; failures++;
        $display("FAIL rnd_no_gnt t=%0d got=none exp=gnt req=%b", t, req);
        break;
      end
    end
    checks++;
    if (ng < 60) begin failures++; $display("FAIL rnd_budget got=%0d exp=60 grants", ng); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_divzero();
    test_operand_stability();
    test_watchdog();
    test_reset_mid_op();
    test_fairness();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
